// File: rtl/router_pkg.sv
// Shared router types: flit format, port identifiers, the switch-facing
// pipeline bus, the input-port state encoding and the XY routing rule.
package router_pkg;

  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    INVALID_FLIT = 2'd0,
    HEAD_FLIT    = 2'd1,
    BODY_FLIT    = 2'd2,
    TAIL_FLIT    = 2'd3
  } FLIT_TYPE;

  typedef enum logic [2:0] {
    LOCAL_PORT = 3'd0,
    NORTH_PORT = 3'd1,
    EAST_PORT  = 3'd2,
    SOUTH_PORT = 3'd3,
    WEST_PORT  = 3'd4,
    NONE_PORT  = 3'd5
  } PORT_T;

  typedef struct packed {
    FLIT_TYPE               flit_type;
    logic [COORD_W-1:0]     dst_x;
    logic [COORD_W-1:0]     dst_y;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  typedef struct packed {
    flit_t flit;
    PORT_T target_port;
  } router_pipeline_bus_t;

  typedef enum logic [1:0] {
    IP_IDLE   = 2'd0,
    IP_REQ    = 2'd1,
    IP_ACTIVE = 2'd2
  } IP_STATE_T;

  // Dimension-order routing: resolve X first, then Y, else deliver locally.
  function automatic PORT_T xy_route(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] here_x,
    input logic [COORD_W-1:0] here_y
  );
    if (dst_x > here_x)      return EAST_PORT;
    else if (dst_x < here_x) return WEST_PORT;
    else if (dst_y > here_y) return NORTH_PORT;
    else if (dst_y < here_y) return SOUTH_PORT;
    else                     return LOCAL_PORT;
  endfunction

endpackage

// File: rtl/input_port_unit_flit_fifo.sv
// flit_fifo: circular flit buffer for one router input port.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push        - write push_flit (accepted when not full, or when full
//                 and popping in the same cycle)
//   push_flit   - flit to write
//   pop         - advance read pointer (ignored when empty)
//   head        - flit at the read pointer (valid when !empty)
//   full, empty - occupancy flags
module flit_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  flit_t push_flit,
  input  logic  pop,
  output flit_t head,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  flit_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // A full buffer still takes a write when a slot frees in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= AW'(wr_ptr + 1'b1);
      end
      if (do_pop) begin
        rd_ptr <= AW'(rd_ptr + 1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= CW'(count_q + 1'b1);
        2'b01:   count_q <= CW'(count_q - 1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/input_port_unit.sv
// input_port_unit: per-port ingress stage of the mesh router.
// Buffers incoming flits, XY-routes each head flit, requests the switch
// and, once granted, streams the packet onto the switch pipeline bus.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   i_flit, i_valid    - incoming flit and its valid strobe
//   o_credit           - one-cycle pulse per flit popped from the buffer
//   o_r2s              - flit and target port presented to the switch
//   o_switch_req       - switch allocation request
//   i_routing_success  - switch grant for this port
//   i_out_ready        - downstream output can take a flit this cycle
//   o_err              - sticky protocol error (stray body/tail, overflow)
module input_port_unit
  import router_pkg::*;
#(
  parameter int unsigned        DEPTH  = 4,
  parameter logic [COORD_W-1:0] X_ADDR = '0,
  parameter logic [COORD_W-1:0] Y_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  flit_t                i_flit,
  input  logic                 i_valid,
  output logic                 o_credit,
  output router_pipeline_bus_t o_r2s,
  output logic                 o_switch_req,
  input  logic                 i_routing_success,
  input  logic                 i_out_ready,
  output logic                 o_err
);

  IP_STATE_T state;
  IP_STATE_T next_state;
  PORT_T     route_q;
  PORT_T     route_d;
  logic      err_q;
  logic      err_set;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic      overflow;
  flit_t     fifo_head;

  flit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (i_valid),
    .push_flit(i_flit),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Write into a full buffer with no slot freeing this cycle is dropped.
  assign overflow = i_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IP_IDLE;
      route_q <= NONE_PORT;
      err_q   <= 1'b0;
    end else begin
      state   <= next_state;
      route_q <= route_d;
      if (err_set || overflow) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state             = state;
    route_d                = route_q;
    pop                    = 1'b0;
    err_set                = 1'b0;
    o_switch_req           = 1'b0;
    o_r2s.flit             = '0;
    o_r2s.target_port      = NONE_PORT;
    case (state)
      IP_IDLE: begin
        if (!fifo_empty) begin
          if (fifo_head.flit_type == HEAD_FLIT) begin
            route_d    = xy_route(fifo_head.dst_x, fifo_head.dst_y, X_ADDR, Y_ADDR);
            next_state = IP_REQ;
          end else begin
            // Anything other than a head here is out of packet order:
            // discard it, still returning its buffer slot upstream.
            pop     = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      IP_REQ: begin
        o_switch_req      = 1'b1;
        o_r2s.target_port = route_q;
        if (i_routing_success) begin
          next_state = IP_ACTIVE;
        end
      end
      IP_ACTIVE: begin
        o_r2s.target_port = route_q;
        if (!fifo_empty && i_out_ready) begin
          pop        = 1'b1;
          o_r2s.flit = fifo_head;
          if (fifo_head.flit_type == TAIL_FLIT) begin
            next_state = IP_IDLE;
          end
        end
      end
      default: next_state = IP_IDLE;
    endcase
  end

  assign o_credit = pop;
  assign o_err    = err_q;

endmodule

// File: tb/tb_input_port_unit.sv
module tb_input_port_unit;
  import router_pkg::*;

  localparam int unsigned        DEPTH = 4;
  localparam logic [COORD_W-1:0] XA    = 4'd1;
  localparam logic [COORD_W-1:0] YA    = 4'd1;

  logic                 clk = 1'b0;
  logic                 rst;
  flit_t                i_flit;
  logic                 i_valid;
  logic                 o_credit;
  router_pipeline_bus_t o_r2s;
  logic                 o_switch_req;
  logic                 i_routing_success;
  logic                 i_out_ready;
  logic                 o_err;

  input_port_unit #(
    .DEPTH (DEPTH),
    .X_ADDR(XA),
    .Y_ADDR(YA)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_flit           (i_flit),
    .i_valid          (i_valid),
    .o_credit         (o_credit),
    .o_r2s            (o_r2s),
    .o_switch_req     (o_switch_req),
    .i_routing_success(i_routing_success),
    .i_out_ready      (i_out_ready),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    flit_t f;
    PORT_T p;
  } exp_t;

  exp_t  sb[$];     // flits expected on the switch bus, in order
  flit_t pend[$];   // flits waiting to be injected upstream

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no;
  int credits, presented, req_cycles, first_req, first_flit, last_flit;
  int tot_push = 0;
  int tot_cred = 0;
  int tot_flits;

  logic                 s_credit, s_req, s_err;
  router_pipeline_bus_t s_r2s;
  router_pipeline_bus_t rst_bus;
  PORT_T                cap;

  // Reference routing computed from coordinate differences.
  function automatic PORT_T ref_route(input int dx, input int dy);
    int ex, ey;
    ex = dx - int'(XA);
    ey = dy - int'(YA);
    if (ex != 0) return (ex > 0) ? EAST_PORT : WEST_PORT;
    if (ey != 0) return (ey > 0) ? NORTH_PORT : SOUTH_PORT;
    return LOCAL_PORT;
  endfunction

  function automatic flit_t mk(input FLIT_TYPE t, input int dx, input int dy,
                               input logic [PAYLOAD_W-1:0] pl);
    flit_t f;
    f.flit_type = t;
    f.dst_x     = COORD_W'(dx);
    f.dst_y     = COORD_W'(dy);
    f.payload   = pl;
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cyc_no     = 0;
    credits    = 0;
    presented  = 0;
    req_cycles = 0;
    first_req  = -1;
    first_flit = -1;
    last_flit  = -1;
  endtask

  task automatic add_pkt(input int dx, input int dy, input int nb);
    exp_t  e;
    flit_t f;
    FLIT_TYPE t;
    for (int i = 0; i < nb + 2; i++) begin
      t = (i == 0) ? HEAD_FLIT : ((i == nb + 1) ? TAIL_FLIT : BODY_FLIT);
      f = mk(t, dx, dy, PAYLOAD_W'($urandom));
      pend.push_back(f);
      e.f = f;
      e.p = ref_route(dx, dy);
      sb.push_back(e);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, score, advance.
  task automatic step(input logic v, input flit_t f, input logic g, input logic rdy);
    exp_t e;
    i_valid           = v;
    i_flit            = v ? f : '0;
    i_routing_success = g;
    i_out_ready       = rdy;
    #3;
    s_credit = o_credit;
    s_req    = o_switch_req;
    s_r2s    = o_r2s;
    s_err    = o_err;
    if (!rst) begin
      if (s_credit) begin
        credits++;
        tot_cred++;
      end
      if (s_req) begin
        req_cycles++;
        if (first_req < 0) first_req = cyc_no;
        check("req_bubble", s_r2s.flit, '0);
      end
      if (s_r2s.flit.flit_type != INVALID_FLIT) begin
        presented++;
        if (first_flit < 0) first_flit = cyc_no;
        last_flit = cyc_no;
        if (sb.size() == 0) begin
          check("unexpected_flit", s_r2s, '0);
        end else begin
          e = sb.pop_front();
          check("flit", s_r2s.flit, e.f);
          check("port", s_r2s.target_port, e.p);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // Inject from pend while respecting the upstream credit window.
  task automatic tick(input logic g, input logic rdy);
    flit_t f;
    logic  v;
    v = (pend.size() > 0) && ((tot_push - tot_cred) < int'(DEPTH));
    f = '0;
    if (v) begin
      f = pend.pop_front();
      tot_push++;
    end
    step(v, f, g, rdy);
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((pend.size() > 0 || sb.size() > 0) && k < bound) begin
      tick(1'b1, 1'b1);
      k++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    pend.delete();
    sb.delete();
    tot_push = 0;
    tot_cred = 0;
  endtask

  initial begin
    rst_bus.flit        = '0;
    rst_bus.target_port = NONE_PORT;
    rst               = 1'b1;
    i_valid           = 1'b0;
    i_flit            = '0;
    i_routing_success = 1'b0;
    i_out_ready       = 1'b0;
    clr_stats();
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b0, 1'b0);
    do_reset();

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0);
    check("rst_credit", s_credit, 1'b0);
    check("rst_req", s_req, 1'b0);
    check("rst_r2s", s_r2s, rst_bus);
    check("rst_err", s_err, 1'b0);
    check("rst_count", dut.u_fifo.count_q, 0);
    check("rst_state", dut.state, IP_IDLE);
    check("rst_route", dut.route_q, NONE_PORT);

    // HEAD(3,1), BODY, TAIL back-to-back, immediate grant
    clr_stats();
    add_pkt(3, 1, 1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    check("t1_first_req", first_req, 2);
    check("t1_req_cycles", req_cycles, 1);
    check("t1_first_flit", first_flit, 3);
    check("t1_presented", presented, 3);
    check("t1_consecutive", last_flit - first_flit, 2);
    check("t1_credits", credits, 3);
    check("t1_route", dut.route_q, EAST_PORT);
    check("t1_state", dut.state, IP_IDLE);
    check("t1_sb_empty", sb.size(), 0);

    // Route sweep at router (1,1)
    begin
      int    sx[5];
      int    sy[5];
      PORT_T sp[5];
      sx = '{0, 1, 1, 1, 2};
      sy = '{1, 2, 0, 1, 0};
      sp = '{WEST_PORT, NORTH_PORT, SOUTH_PORT, LOCAL_PORT, EAST_PORT};
      for (int i = 0; i < 5; i++) begin
        clr_stats();
        cap = NONE_PORT;
        add_pkt(sx[i], sy[i], 0);
        for (int k = 0; k < 10; k++) begin
          tick(1'b1, 1'b1);
          if (s_req) cap = s_r2s.target_port;
        end
        check("sweep_port", cap, sp[i]);
        check("sweep_done", sb.size(), 0);
      end
    end

    // Grant withheld for 5 request cycles
    clr_stats();
    add_pkt(0, 3, 1);
    begin
      int k;
      k = 0;
      s_req = 1'b0;
      while (!s_req && k < 10) begin
        tick(1'b0, 1'b1);
        k++;
      end
      check("hold_req_seen", s_req, 1'b1);
      for (int i = 0; i < 4; i++) begin
        tick(1'b0, 1'b1);
        check("hold_req", s_req, 1'b1);
        check("hold_credit", s_credit, 1'b0);
        check("hold_port", s_r2s.target_port, ref_route(0, 3));
      end
      check("hold_req_cycles", req_cycles, 5);
      check("hold_no_pop", credits, 0);
    end
    drain(20);
    check("hold_presented", presented, 3);

    // Fill to DEPTH with output stalled, then push+pop while full
    clr_stats();
    add_pkt(2, 2, 4);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    check("full_count", dut.u_fifo.count_q, DEPTH);
    check("full_no_credit", credits, 0);
    begin
      flit_t f;
      f = pend.pop_front();
      tot_push++;
      step(1'b1, f, 1'b1, 1'b1);
    end
    check("full_pp_credit", s_credit, 1'b1);
    check("full_pp_count", dut.u_fifo.count_q, DEPTH);
    check("full_pp_err", o_err, 1'b0);
    drain(30);
    check("full_presented", presented, 6);

    // Stray BODY while idle
    clr_stats();
    step(1'b1, mk(BODY_FLIT, 2, 1, 16'h5a5a), 1'b1, 1'b1);
    tot_push++;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("stray_credit", credits, 1);
    check("stray_req", req_cycles, 0);
    check("stray_err", o_err, 1'b1);
    check("stray_count", dut.u_fifo.count_q, 0);

    // Reset in the middle of a packet's body flits
    do_reset();
    check("mid_err_clr", o_err, 1'b0);
    clr_stats();
    add_pkt(0, 0, 4);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    check("mid_in_progress", presented, 2);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b0);
    check("mid_credit", s_credit, 1'b0);
    check("mid_req", s_req, 1'b0);
    check("mid_r2s", s_r2s, rst_bus);
    check("mid_err", s_err, 1'b0);
    check("mid_count", dut.u_fifo.count_q, 0);
    check("mid_state", dut.state, IP_IDLE);
    check("mid_route", dut.route_q, NONE_PORT);
    clr_stats();
    add_pkt(3, 3, 1);
    drain(20);
    check("post_presented", presented, 3);
    check("post_req_cycles", req_cycles, 1);
    check("post_route", dut.route_q, EAST_PORT);

    // Randomized packet stream with random grant/ready
    clr_stats();
    tot_flits = 0;
    for (int p = 0; p < 40; p++) begin
      int nb;
      nb = int'($urandom_range(0, 3));
      tot_flits += nb + 2;
      add_pkt(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), nb);
    end
    begin
      int k;
      k = 0;
      while ((pend.size() > 0 || sb.size() > 0) && k < 4000) begin
        tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        k++;
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("rand_sb_empty", sb.size(), 0);
    check("rand_presented", presented, tot_flits);
    check("rand_credits", tot_cred, tot_push);
    check("rand_err", o_err, 1'b0);
    check("rand_state", dut.state, IP_IDLE);
    check("rand_count", dut.u_fifo.count_q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
